lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lcd_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// Character LCD refresh controller: 32-byte text buffer streamed through an external LCD write block.
// Define LCD_CTRL_LINE2_EN to enable the second display line (function set 0x38, 38 transfers).
module lcd_ctrl #(
  parameter int CMD_DELAY = 250000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iWr,
  input  logic [4:0] iWrAddr,
  input  logic [7:0] iWrData,
  input  logic       iRefresh,
  output logic       oBusy,
  output logic [7:0] oDATA,
  output logic       oRS,
  output logic       oStart,
  input  logic       iDone
);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DELAY = 3'd3;
  localparam logic [2:0] S_IDLE  = 3'd4;

`ifdef LCD_CTRL_LINE2_EN
  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [5:0] LAST_IDX = 6'd37;
`else
  localparam logic [7:0] FUNC_SET = 8'h30;
  localparam logic [5:0] LAST_IDX = 6'd20;
`endif

  localparam logic [5:0]  REFRESH_IDX = 6'd4;
  localparam logic [17:0] DELAY_LAST  = 18'(CMD_DELAY - 1);

  logic [7:0]  mem_q [32];
  logic [2:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [17:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        done_q;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        start_q, start_d;
  logic [7:0]  ld_data;
  logic        ld_rs;
  logic [4:0]  rd_addr;

  // Byte and register-select for the current sequence index.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ld_data = 8'h00;
    ld_rs   = 1'b0;
    rd_addr = 5'd0;
    if (idx_q <= 6'd4) begin
      case (idx_q[2:0])
        3'd0:    ld_data = FUNC_SET;
        3'd1:    ld_data = 8'h0C;
        3'd2:    ld_data = 8'h01;
        3'd3:    ld_data = 8'h06;
        default: ld_data = 8'h80;
      endcase
    end else if (idx_q <= 6'd20) begin
      rd_addr = 5'(idx_q - 6'd5);
      ld_data = mem_q[rd_addr];
      ld_rs   = 1'b1;
    end else if (idx_q == 6'd21) begin
      ld_data = 8'hC0;
    end else begin
      rd_addr = 5'(idx_q - 6'd6);
      ld_data = mem_q[rd_addr];
      ld_rs   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | iRefresh;
    data_d  = data_q;
    rs_d    = rs_q;
    start_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        data_d  = ld_data;
        rs_d    = ld_rs;
        state_d = S_START;
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only a fresh rising edge of iDone completes the transfer.
        if (iDone && !done_q) begin
          cnt_d   = '0;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 6'd1;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 18'd1;
        end
      end
      S_IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          idx_d   = REFRESH_IDX;
          state_d = S_LOAD;
        end else begin
          pend_d = iRefresh;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= iDone;
      data_q  <= data_d;
      rs_q    <= rs_d;
      start_q <= start_d;
    end
  end

  // NOTE: the text buffer is reset to spaces, so it must be flops rather than a RAM macro.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
    end else if (iWr) begin
      mem_q[iWrAddr] <= iWrData;
    end
  end

  assign oBusy  = (state_q != S_IDLE) || pend_q;
  assign oDATA  = data_q;
  assign oRS    = rs_q;
  assign oStart = start_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl with a behavioural LCD write-block responder.
// Expectations follow LCD_CTRL_LINE2_EN when it is defined for the build.
module tb_lcd_ctrl;

`ifdef LCD_CTRL_LINE2_EN
  localparam logic [7:0] FSET = 8'h38;
  localparam int         LAST = 37;
`else
  localparam logic [7:0] FSET = 8'h30;
  localparam int         LAST = 20;
`endif
  localparam int BOUND = 4000;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       iWr;
  logic [4:0] iWrAddr;
  logic [7:0] iWrData;
  logic       iRefresh;
  logic       oBusy;
  logic [7:0] oDATA;
  logic       oRS;
  logic       oStart;
  logic       iDone;

  int total = 0;
  int bad   = 0;

  logic [8:0] log_q[$];
  logic [7:0] bm [32];
  bit         idle_level = 1'b0;
  int         resp_gap   = 2;
  int         cyc        = 0;
  int         last_done_cyc = 0;
  int         last_gap   = 0;
  int         start_cycles = 0;
  int         start_pulses = 0;
  logic       start_prev = 1'b0;

  lcd_ctrl #(.CMD_DELAY(4)) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iWr     (iWr),
    .iWrAddr (iWrAddr),
    .iWrData (iWrData),
    .iRefresh(iRefresh),
    .oBusy   (oBusy),
    .oDATA   (oDATA),
    .oRS     (oRS),
    .oStart  (oStart),
    .iDone   (iDone)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) begin
    start_prev <= oStart;
    if (oStart === 1'b1) begin
      start_cycles <= start_cycles + 1;
      if (start_prev !== 1'b1) start_pulses <= start_pulses + 1;
    end
  end

  // LCD write-block model: logs each started transfer and answers with a 0->1 edge on iDone.
  initial begin
    iDone = 1'b0;
    forever begin
      @(negedge iCLK);
      if (oStart === 1'b1) begin
        log_q.push_back({oRS, oDATA});
        last_gap = cyc - last_done_cyc;
        repeat (resp_gap) @(negedge iCLK);
        iDone = 1'b0;
        @(negedge iCLK);
        iDone = 1'b1;
        last_done_cyc = cyc;
        @(negedge iCLK);
        iDone = 1'b0;
      end else begin
        iDone = idle_level;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_xfer(input int k);
    case (k)
      0: return {1'b0, FSET};
      1: return {1'b0, 8'h0C};
      2: return {1'b0, 8'h01};
      3: return {1'b0, 8'h06};
      4: return {1'b0, 8'h80};
      21: return {1'b0, 8'hC0};
      default: return (k <= 20) ? {1'b1, bm[k-5]} : {1'b1, bm[k-6]};
    endcase
  endfunction

  task automatic compare_seq(input string tag, input int first, input int reps);
    int per;
    int n;
    per = LAST - first + 1;
    check({tag, "_count"}, log_q.size(), per * reps);
    n = (log_q.size() < per * reps) ? log_q.size() : per * reps;
    for (int i = 0; i < n; i++)
      check($sformatf("%s_x%0d", tag, i), {23'b0, log_q[i]}, {23'b0, exp_xfer(first + (i % per))});
  endtask

  function automatic int count_cmd(input logic [7:0] cmd);
    int c = 0;
    foreach (log_q[i]) if (log_q[i] === {1'b0, cmd}) c++;
    return c;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (oBusy !== 1'b0 && n < BOUND) begin
      @(negedge iCLK);
      n++;
    end
    check({tag, "_idle"}, {31'b0, oBusy}, 32'd0);
  endtask

  task automatic pulse_refresh();
    @(negedge iCLK);
    iRefresh = 1'b1;
    @(negedge iCLK);
    iRefresh = 1'b0;
  endtask

  task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
    @(negedge iCLK);
    iWr = 1'b1;
    iWrAddr = a;
    iWrData = d;
    @(negedge iCLK);
    iWr = 1'b0;
    bm[a] = d;
  endtask

  initial begin
    int n;
    int sp0;
    int sc0;
    iRST_N = 1'b0;
    iWr = 1'b0;
    iWrAddr = '0;
    iWrData = '0;
    iRefresh = 1'b0;
    for (int i = 0; i < 32; i++) bm[i] = 8'h20;

    // Reset values
    #23;
    check("rst_start", {31'b0, oStart}, 32'd0);
    check("rst_rs",    {31'b0, oRS},    32'd0);
    check("rst_data",  {24'b0, oDATA},  32'h00);
    check("rst_busy",  {31'b0, oBusy},  32'd1);

    // Full init sequence after reset release
    sp0 = start_pulses;
    sc0 = start_cycles;
    iRST_N = 1'b1;
    wait_idle("init");
    compare_seq("init", 0, 1);
    check("init_c0_absent_or_once", count_cmd(8'hC0), (LAST == 37) ? 1 : 0);
    check("init_pulses", start_pulses - sp0, LAST + 1);
    check("init_pulse_width", start_cycles - sc0, start_pulses - sp0);
    check("delay_gap", last_gap, 7);

    // Refresh with buffer contents, no init commands
    write_buf(5'd0, 8'h48);
    write_buf(5'd17, 8'h69);
    log_q.delete();
    pulse_refresh();
    check("ref_busy", {31'b0, oBusy}, 32'd1);
    wait_idle("ref");
    compare_seq("ref", 4, 1);
    check("ref_first", {23'b0, log_q[0]}, {23'b0, 9'h080});
    check("ref_H", {23'b0, log_q[1]}, {23'b0, 9'h148});
    check("ref_no_fset", count_cmd(FSET), 0);
    check("ref_no_c0_line1", count_cmd(8'hC0), (LAST == 37) ? 1 : 0);

    // Three requests during a refresh collapse into one more; a late write shows up in the first pass
    log_q.delete();
    pulse_refresh();
    repeat (20) @(negedge iCLK);
    write_buf(5'd15, 8'h21);
    pulse_refresh();
    repeat (40) @(negedge iCLK);
    pulse_refresh();
    repeat (40) @(negedge iCLK);
    pulse_refresh();
    wait_idle("multi");
    compare_seq("multi", 4, 2);

    // Static-high iDone must not complete a transfer
    log_q.delete();
    idle_level = 1'b1;
    resp_gap = 12;
    repeat (3) @(negedge iCLK);
    sp0 = start_pulses;
    sc0 = start_cycles;
    pulse_refresh();
    n = 0;
    while (start_pulses == sp0 && n < 50) begin
      @(negedge iCLK);
      n++;
    end
    repeat (10) @(negedge iCLK);
    check("hold_one_start", start_pulses - sp0, 1);
    check("hold_busy", {31'b0, oBusy}, 32'd1);
    idle_level = 1'b0;
    resp_gap = 2;
    wait_idle("hold");
    compare_seq("hold", 4, 1);
    check("hold_pulses", start_pulses - sp0, LAST - 3);
    check("hold_pulse_width", start_cycles - sc0, start_pulses - sp0);

    // Asynchronous reset during index 10, then full restart
    log_q.delete();
    pulse_refresh();
    n = 0;
    while (log_q.size() < 7 && n < BOUND) begin
      @(negedge iCLK);
      n++;
    end
    @(posedge iCLK);
    #3;
    check("mid_rs", {31'b0, oRS}, 32'd1);
    check("mid_data", {24'b0, oDATA}, 32'h20);
    iRST_N = 1'b0;
    #1;
    check("arst_rs",    {31'b0, oRS},    32'd0);
    check("arst_data",  {24'b0, oDATA},  32'h00);
    check("arst_start", {31'b0, oStart}, 32'd0);
    check("arst_busy",  {31'b0, oBusy},  32'd1);
    repeat (20) @(negedge iCLK);
    log_q.delete();
    for (int i = 0; i < 32; i++) bm[i] = 8'h20;
    iRST_N = 1'b1;
    wait_idle("restart");
    compare_seq("restart", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
